mips_pipelined_cpu: RTL and testbench

- Classic 5-stage (IF/ID/EX/MEM/WB) 32-bit MIPS integer core with its own instruction memory, data memory and register file.
- Top-level CPU block; its only ports are clock and reset.
- Benches preload the memories and register file through hierarchy, then observe internal probe signals.

---
 rtl/mips_pipelined_cpu.sv | 323 ++++++++++++++++++++++++++++++++
 tb/tb_mips_pipelined_cpu.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_pipelined_cpu.sv
// rtl/mips_pipelined_cpu.sv - 5-stage MIPS core with private memories; `define HILO_DIV_EN adds DIVU/MFHI/MFLO

module mips_byte_mem #(
  parameter int unsigned BYTES = 1024,
  parameter int unsigned AW    = $clog2(BYTES)
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);
  logic [7:0]    mem_array [0:BYTES-1];
  logic [AW-1:0] a1, a2, a3;

  // Little-endian word read; upper byte lanes wrap modulo the memory size.
  always_comb begin
    a1      = addr_i + AW'(1);
    a2      = addr_i + AW'(2);
    a3      = addr_i + AW'(3);
    rdata_o = {mem_array[a3], mem_array[a2], mem_array[a1], mem_array[addr_i]};
  end

  // Word store; contents are never reset so preloaded images survive.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_array[addr_i] <= wdata_i[7:0];
      mem_array[a1]     <= wdata_i[15:8];
      mem_array[a2]     <= wdata_i[23:16];
      mem_array[a3]     <= wdata_i[31:24];
    end
  end
endmodule

module mips_regfile (
  input  logic        clk_i,
  input  logic        we_i,
  input  logic [4:0]  wa_i,
  input  logic [31:0] wd_i,
  input  logic [4:0]  ra1_i,
  input  logic [4:0]  ra2_i,
  output logic [31:0] rd1_o,
  output logic [31:0] rd2_o
);
  logic [31:0] file_array [0:31];

  // Write port; $0 is never written.
  always_ff @(posedge clk_i) begin
    if (we_i && wa_i != 5'd0) file_array[wa_i] <= wd_i;
  end

  // Read ports with write-through bypass so ID sees the value WB writes this cycle.
  always_comb begin
    rd1_o = file_array[ra1_i];
    if (we_i && wa_i == ra1_i) rd1_o = wd_i;
    if (ra1_i == 5'd0) rd1_o = 32'd0;
    rd2_o = file_array[ra2_i];
    if (we_i && wa_i == ra2_i) rd2_o = wd_i;
    if (ra2_i == 5'd0) rd2_o = 32'd0;
  end
endmodule

module mips_pipelined_cpu #(
  parameter int unsigned IMEM_BYTES = 1024,
  parameter int unsigned DMEM_BYTES = 1024
) (
  input logic clk,
  input logic rst
);
  localparam int unsigned IAW = $clog2(IMEM_BYTES);
  localparam int unsigned DAW = $clog2(DMEM_BYTES);

  typedef enum logic [3:0] {
    ALU_NOP, ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT, ALU_SLL, ALU_DIVU, ALU_MFHI, ALU_MFLO
  } alu_op_e;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
  } ifid_t;

  typedef struct packed {
    logic [31:0] pc4;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] imm;
    logic [4:0]  shamt;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  dest;
    alu_op_e     alu_op;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        use_imm;
    logic        beq;
    logic        bne;
  } idex_t;

  typedef struct packed {
    logic [31:0] result;
    logic [31:0] sdata;
    logic [4:0]  dest;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
  } exmem_t;

  typedef struct packed {
    logic [31:0] result;
    logic [4:0]  dest;
    logic        reg_write;
  } memwb_t;

  logic [31:0] pc_q, pc_d, pc;
  ifid_t       ifid_q, ifid_d;
  idex_t       idex_q, idex_d, id_ctl;
  exmem_t      exmem_q, exmem_d;
  memwb_t      memwb_q, memwb_d;

  logic [31:0] if_instr, dmem_rdata, rf_rd1, rf_rd2, rfile_wd;
  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd, shamt;
  logic        id_jump, load_use;
  logic [31:0] ex_a, ex_b, ex_op_b, ex_result, ex_target;
  logic        ex_taken;

  assign pc = pc_q;

  // ---------------- IF ----------------
  mips_byte_mem #(.BYTES(IMEM_BYTES)) InstrMem (
    .clk_i   (clk),
    .we_i    (1'b0),
    .addr_i  (pc[IAW-1:0]),
    .wdata_i (32'd0),
    .rdata_o (if_instr)
  );

  // ---------------- ID ----------------
  assign opcode = ifid_q.instr[31:26];
  assign rs     = ifid_q.instr[25:21];
  assign rt     = ifid_q.instr[20:16];
  assign rd     = ifid_q.instr[15:11];
  assign shamt  = ifid_q.instr[10:6];
  assign funct  = ifid_q.instr[5:0];

  mips_regfile RegFile (
    .clk_i (clk),
    .we_i  (memwb_q.reg_write & rst),
    .wa_i  (memwb_q.dest),
    .wd_i  (rfile_wd),
    .ra1_i (rs),
    .ra2_i (rt),
    .rd1_o (rf_rd1),
    .rd2_o (rf_rd2)
  );

  // Decode the IF/ID instruction into the ID/EX control bundle; unknown encodings become NOPs.
  always_comb begin
    id_ctl        = '0;
    id_ctl.pc4    = ifid_q.pc4;
    id_ctl.a      = rf_rd1;
    id_ctl.b      = rf_rd2;
    id_ctl.imm    = {{16{ifid_q.instr[15]}}, ifid_q.instr[15:0]};
    id_ctl.shamt  = shamt;
    id_ctl.rs     = rs;
    id_ctl.rt     = rt;
    id_jump       = 1'b0;
    case (opcode)
      6'd0: begin
        id_ctl.dest = rd;
        case (funct)
          6'd32: begin id_ctl.alu_op = ALU_ADD; id_ctl.reg_write = 1'b1; end
          6'd34: begin id_ctl.alu_op = ALU_SUB; id_ctl.reg_write = 1'b1; end
          6'd36: begin id_ctl.alu_op = ALU_AND; id_ctl.reg_write = 1'b1; end
          6'd37: begin id_ctl.alu_op = ALU_OR;  id_ctl.reg_write = 1'b1; end
          6'd42: begin id_ctl.alu_op = ALU_SLT; id_ctl.reg_write = 1'b1; end
          6'd0:  begin id_ctl.alu_op = ALU_SLL; id_ctl.reg_write = 1'b1; end
`ifdef HILO_DIV_EN
          6'd27: id_ctl.alu_op = ALU_DIVU;
          6'd16: begin id_ctl.alu_op = ALU_MFHI; id_ctl.reg_write = 1'b1; end
          6'd18: begin id_ctl.alu_op = ALU_MFLO; id_ctl.reg_write = 1'b1; end
`endif
          default: id_ctl.dest = 5'd0;
        endcase
      end
      6'd35: begin
        id_ctl.alu_op    = ALU_ADD;
        id_ctl.use_imm   = 1'b1;
        id_ctl.mem_read  = 1'b1;
        id_ctl.reg_write = 1'b1;
        id_ctl.dest      = rt;
      end
      6'd43: begin
        id_ctl.alu_op    = ALU_ADD;
        id_ctl.use_imm   = 1'b1;
        id_ctl.mem_write = 1'b1;
      end
      6'd4:    id_ctl.beq = 1'b1;
      6'd5:    id_ctl.bne = 1'b1;
      6'd2:    id_jump = 1'b1;
      default: ;
    endcase
  end

  // A load in EX whose destination is named by the ID instruction forces one bubble.
  assign load_use = idex_q.mem_read && idex_q.dest != 5'd0 &&
                    (idex_q.dest == rs || idex_q.dest == rt);

  // ---------------- EX ----------------
  // Operand forwarding: the younger EX/MEM result wins over MEM/WB.
  always_comb begin
    ex_a = idex_q.a;
    if (exmem_q.reg_write && exmem_q.dest != 5'd0 && exmem_q.dest == idex_q.rs)
      ex_a = exmem_q.result;
    else if (memwb_q.reg_write && memwb_q.dest != 5'd0 && memwb_q.dest == idex_q.rs)
      ex_a = memwb_q.result;
    ex_b = idex_q.b;
    if (exmem_q.reg_write && exmem_q.dest != 5'd0 && exmem_q.dest == idex_q.rt)
      ex_b = exmem_q.result;
    else if (memwb_q.reg_write && memwb_q.dest != 5'd0 && memwb_q.dest == idex_q.rt)
      ex_b = memwb_q.result;
  end

`ifdef HILO_DIV_EN
  logic [31:0] hi_q, lo_q;

  // DIVU commits HI/LO as it leaves EX so a following MFHI/MFLO sees the result.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hi_q <= 32'd0;
      lo_q <= 32'd0;
    end else if (idex_q.alu_op == ALU_DIVU) begin
      if (ex_b == 32'd0) begin
        hi_q <= ex_a;
        lo_q <= 32'hFFFF_FFFF;
      end else begin
        hi_q <= ex_a % ex_b;
        lo_q <= ex_a / ex_b;
      end
    end
  end
`endif

  // ALU and branch resolution.
  always_comb begin
    ex_op_b   = idex_q.use_imm ? idex_q.imm : ex_b;
    ex_result = 32'd0;
    case (idex_q.alu_op)
      ALU_ADD:  ex_result = ex_a + ex_op_b;
      ALU_SUB:  ex_result = ex_a - ex_op_b;
      ALU_AND:  ex_result = ex_a & ex_op_b;
      ALU_OR:   ex_result = ex_a | ex_op_b;
      ALU_SLT:  ex_result = {31'd0, $signed(ex_a) < $signed(ex_op_b)};
      ALU_SLL:  ex_result = ex_b << idex_q.shamt;
`ifdef HILO_DIV_EN
      ALU_MFHI: ex_result = hi_q;
      ALU_MFLO: ex_result = lo_q;
`endif
      default:  ex_result = 32'd0;
    endcase
    ex_taken  = (idex_q.beq && ex_a == ex_b) || (idex_q.bne && ex_a != ex_b);
    ex_target = idex_q.pc4 + {idex_q.imm[29:0], 2'b00};
  end

  // ---------------- MEM ----------------
  mips_byte_mem #(.BYTES(DMEM_BYTES)) DatMem (
    .clk_i   (clk),
    .we_i    (exmem_q.mem_write & rst),
    .addr_i  (exmem_q.result[DAW-1:0]),
    .wdata_i (exmem_q.sdata),
    .rdata_o (dmem_rdata)
  );

  // ---------------- WB ----------------
  assign rfile_wd = memwb_q.result;

  // Next-state of the front end: branch flush beats load-use stall beats jump redirect.
  always_comb begin
    pc_d         = pc + 32'd4;
    ifid_d.instr = if_instr;
    ifid_d.pc4   = pc + 32'd4;
    idex_d       = id_ctl;
    if (ex_taken) begin
      pc_d   = ex_target;
      ifid_d = '0;
      idex_d = '0;
    end else if (load_use) begin
      pc_d   = pc;
      ifid_d = ifid_q;
      idex_d = '0;
    end else if (id_jump) begin
      pc_d   = {ifid_q.pc4[31:28], ifid_q.instr[25:0], 2'b00};
      ifid_d = '0;
    end
    exmem_d.result    = ex_result;
    exmem_d.sdata     = ex_b;
    exmem_d.dest      = idex_q.dest;
    exmem_d.reg_write = idex_q.reg_write;
    exmem_d.mem_read  = idex_q.mem_read;
    exmem_d.mem_write = idex_q.mem_write;
    memwb_d.result    = exmem_q.mem_read ? dmem_rdata : exmem_q.result;
    memwb_d.dest      = exmem_q.dest;
    memwb_d.reg_write = exmem_q.reg_write;
  end

  // Pipeline registers; reset aborts everything in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q    <= 32'd0;
      ifid_q  <= '0;
      idex_q  <= '0;
      exmem_q <= '0;
      memwb_q <= '0;
    end else begin
      pc_q    <= pc_d;
      ifid_q  <= ifid_d;
      idex_q  <= idex_d;
      exmem_q <= exmem_d;
      memwb_q <= memwb_d;
    end
  end
endmodule

// File: tb/tb_mips_pipelined_cpu.sv
// tb/tb_mips_pipelined_cpu.sv - directed and random-program bench for mips_pipelined_cpu
module tb_mips_pipelined_cpu;
  localparam int N = 20;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mips_pipelined_cpu dut (.clk(clk), .rst(rst));

  int errors = 0;
  int checks = 0;

  logic [31:0] prog  [0:255];
  logic [31:0] m_reg [0:31];
  logic [7:0]  m_mem [0:1023];
  logic [31:0] m_hi, m_lo;
  int          nprog;

  logic [31:0] lu_seq [0:4] = '{32'd0, 32'd4, 32'd8, 32'd8, 32'd12};
  logic [31:0] br_seq [0:7] = '{32'd0, 32'd4, 32'd8, 32'd12, 32'd16, 32'd20, 32'd24, 32'd32};
  logic [31:0] j_seq  [0:2] = '{32'd0, 32'd4, 32'h10};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] enc_r(input int s, input int t, input int d, input int sh, input int fn);
    return {6'd0, 5'(s), 5'(t), 5'(d), 5'(sh), 6'(fn)};
  endfunction
  function automatic logic [31:0] enc_i(input int op, input int s, input int t, input int imm);
    return {6'(op), 5'(s), 5'(t), 16'(imm)};
  endfunction
  function automatic logic [31:0] enc_j(input int target);
    return {6'd2, 26'(target >> 2)};
  endfunction

  function automatic logic [31:0] dmem_word(input int a);
    return {dut.DatMem.mem_array[(a + 3) % 1024], dut.DatMem.mem_array[(a + 2) % 1024],
            dut.DatMem.mem_array[(a + 1) % 1024], dut.DatMem.mem_array[a % 1024]};
  endfunction

  task automatic prep();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 1024; i++) begin
      dut.InstrMem.mem_array[i] = 8'd0;
      dut.DatMem.mem_array[i]   = 8'd0;
      m_mem[i]                  = 8'd0;
    end
    for (int i = 0; i < 32; i++) begin
      dut.RegFile.file_array[i] = 32'd0;
      m_reg[i]                  = 32'd0;
    end
    nprog = 0;
  endtask

  task automatic emit(input logic [31:0] w);
    prog[nprog] = w;
    for (int b = 0; b < 4; b++) dut.InstrMem.mem_array[nprog * 4 + b] = w[8*b +: 8];
    nprog++;
  endtask

  task automatic set_reg(input int i, input logic [31:0] v);
    dut.RegFile.file_array[i] = v;
    m_reg[i] = v;
  endtask

  task automatic set_byte(input int a, input logic [7:0] v);
    dut.DatMem.mem_array[a] = v;
    m_mem[a] = v;
  endtask

  task automatic go();
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic m_wr(input logic [4:0] idx, input logic [31:0] v);
    if (idx != 5'd0) m_reg[idx] = v;
  endtask

  // Instruction-at-a-time architectural model: no pipeline, just the ISA rules.
  task automatic model_run();
    logic [31:0] pcm, w, s, t, imm, a, npc;
    int steps;
    pcm = 0; steps = 0; m_hi = 0; m_lo = 0;
    while (pcm != 32'((nprog - 1) * 4) && steps < 1000) begin
      w   = prog[pcm / 4];
      s   = m_reg[w[25:21]];
      t   = m_reg[w[20:16]];
      imm = {{16{w[15]}}, w[15:0]};
      a   = s + imm;
      npc = pcm + 4;
      case (w[31:26])
        6'd0: case (w[5:0])
          6'd32: m_wr(w[15:11], s + t);
          6'd34: m_wr(w[15:11], s - t);
          6'd36: m_wr(w[15:11], s & t);
          6'd37: m_wr(w[15:11], s | t);
          6'd42: m_wr(w[15:11], ($signed(s) < $signed(t)) ? 32'd1 : 32'd0);
          6'd0:  m_wr(w[15:11], t << w[10:6]);
`ifdef HILO_DIV_EN
          6'd27: begin
            if (t == 0) begin m_hi = s; m_lo = 32'hFFFF_FFFF; end
            else begin m_hi = s % t; m_lo = s / t; end
          end
          6'd16: m_wr(w[15:11], m_hi);
          6'd18: m_wr(w[15:11], m_lo);
`endif
          default: ;
        endcase
        6'd35: m_wr(w[20:16], {m_mem[(a + 3) % 1024], m_mem[(a + 2) % 1024],
                               m_mem[(a + 1) % 1024], m_mem[a % 1024]});
        6'd43: for (int k = 0; k < 4; k++) m_mem[(a + 32'(k)) % 1024] = t[8*k +: 8];
        6'd4:  if (s == t) npc = pcm + 4 + (imm << 2);
        6'd5:  if (s != t) npc = pcm + 4 + (imm << 2);
        default: ;
      endcase
      pcm = npc;
      steps++;
    end
  endtask

  task automatic gen_random_program();
    int kind, ra, rb, rdst, off, nkind;
`ifdef HILO_DIV_EN
    nkind = 13;
`else
    nkind = 10;
`endif
    for (int i = 0; i < N; i++) begin
      kind = $urandom_range(0, nkind - 1);
      ra   = $urandom_range(0, 7);
      rb   = $urandom_range(0, 7);
      rdst = $urandom_range(0, 7);
      off  = $urandom_range(0, (N - 1 - i) < 3 ? (N - 1 - i) : 3);
      case (kind)
        0:  emit(enc_r(ra, rb, rdst, 0, 32));
        1:  emit(enc_r(ra, rb, rdst, 0, 34));
        2:  emit(enc_r(ra, rb, rdst, 0, 36));
        3:  emit(enc_r(ra, rb, rdst, 0, 37));
        4:  emit(enc_r(ra, rb, rdst, 0, 42));
        5:  emit(enc_r(0, rb, rdst, $urandom_range(0, 31), 0));
        6:  emit(enc_i(35, ra, rdst, int'($urandom_range(0, 63)) - 32));
        7:  emit(enc_i(43, ra, rb, int'($urandom_range(0, 63)) - 32));
        8:  emit(enc_i(4, ra, rb, off));
        9:  emit(enc_i(5, ra, rb, off));
        10: emit(enc_r(ra, rb, 0, 0, 27));
        11: emit(enc_r(0, 0, rdst, 0, 16));
        default: emit(enc_r(0, 0, rdst, 0, 18));
      endcase
    end
    emit(enc_j(N * 4));
  endtask

  initial begin
    // Reset and NOP flow
    prep();
    go();
    for (int k = 0; k < 4; k++) begin
      check_eq("reset_pc", dut.pc, 32'(4 * k));
      check_eq("reset_wd", dut.rfile_wd, 32'd0);
      @(negedge clk);
    end

    // ALU chain with back-to-back dependencies
    prep();
    set_reg(1, 32'd5);
    set_reg(2, 32'd3);
    emit(enc_r(1, 2, 3, 0, 32));
    emit(enc_r(3, 1, 4, 0, 34));
    emit(enc_r(2, 1, 5, 0, 42));
    emit(enc_r(1, 2, 12, 0, 36));
    emit(enc_r(1, 2, 13, 0, 37));
    emit(enc_r(0, 1, 6, 2, 0));
    emit(enc_j(24));
    go();
    repeat (5) @(negedge clk);
    check_eq("alu_nostall_pc", dut.pc, 32'd20);
    repeat (15) @(negedge clk);
    check_eq("alu_add", dut.RegFile.file_array[3], 32'd8);
    check_eq("alu_sub", dut.RegFile.file_array[4], 32'd3);
    check_eq("alu_slt", dut.RegFile.file_array[5], 32'd1);
    check_eq("alu_and", dut.RegFile.file_array[12], 32'd1);
    check_eq("alu_or",  dut.RegFile.file_array[13], 32'd7);
    check_eq("alu_sll", dut.RegFile.file_array[6], 32'd20);

    // Load-use stall and store
    prep();
    set_byte(0, 8'h78); set_byte(1, 8'h56); set_byte(2, 8'h34); set_byte(3, 8'h12);
    emit(enc_i(35, 0, 7, 0));
    emit(enc_r(7, 7, 8, 0, 32));
    emit(enc_i(43, 0, 8, 4));
    emit(enc_j(12));
    go();
    for (int k = 0; k < 5; k++) begin
      check_eq("lu_pc", dut.pc, lu_seq[k]);
      if (k == 1) begin
        check_eq("probe_opcode", 32'(dut.opcode), 32'd35);
        check_eq("probe_rt", 32'(dut.rt), 32'd7);
      end
      @(negedge clk);
    end
    repeat (15) @(negedge clk);
    check_eq("lu_r8", dut.RegFile.file_array[8], 32'h2468ACF0);
    check_eq("lu_store", dmem_word(4), 32'h2468ACF0);

    // Taken BEQ, untaken BNE, J
    prep();
    set_reg(1, 32'd5);
    emit(enc_i(4, 1, 1, 2));
    emit(enc_r(1, 1, 20, 0, 32));
    emit(enc_r(1, 1, 21, 0, 32));
    emit(enc_i(5, 1, 1, 1));
    emit(enc_r(1, 1, 22, 0, 32));
    emit(enc_j(32));
    emit(enc_r(1, 1, 23, 0, 32));
    emit(enc_r(1, 1, 24, 0, 32));
    emit(enc_j(32));
    go();
    for (int k = 0; k < 8; k++) begin
      check_eq("br_pc", dut.pc, br_seq[k]);
      @(negedge clk);
    end
    repeat (10) @(negedge clk);
    check_eq("beq_squash1", dut.RegFile.file_array[20], 32'd0);
    check_eq("beq_squash2", dut.RegFile.file_array[21], 32'd0);
    check_eq("bne_fall",    dut.RegFile.file_array[22], 32'd10);
    check_eq("j_squash",    dut.RegFile.file_array[23], 32'd0);
    check_eq("j_skip",      dut.RegFile.file_array[24], 32'd0);

    // J 0x10 from address 0
    prep();
    set_reg(1, 32'd5);
    emit(enc_j(16));
    emit(enc_r(1, 1, 25, 0, 32));
    emit(32'd0);
    emit(32'd0);
    emit(enc_j(16));
    go();
    for (int k = 0; k < 3; k++) begin
      check_eq("j_pc", dut.pc, j_seq[k]);
      @(negedge clk);
    end
    repeat (10) @(negedge clk);
    check_eq("j_bubble", dut.RegFile.file_array[25], 32'd0);

    // Divide and HI/LO moves
    prep();
    set_reg(1, 32'd17);
    set_reg(2, 32'd5);
    set_reg(9, 32'hA5);  set_reg(10, 32'hA5);
    set_reg(14, 32'hA5); set_reg(15, 32'hA5);
    emit(enc_r(1, 2, 0, 0, 27));
    emit(enc_r(0, 0, 9, 0, 16));
    emit(enc_r(0, 0, 10, 0, 18));
    emit(enc_r(1, 0, 0, 0, 27));
    emit(enc_r(0, 0, 14, 0, 16));
    emit(enc_r(0, 0, 15, 0, 18));
    emit(enc_j(24));
    go();
    repeat (20) @(negedge clk);
`ifdef HILO_DIV_EN
    check_eq("div_hi", dut.RegFile.file_array[9], 32'd2);
    check_eq("div_lo", dut.RegFile.file_array[10], 32'd3);
    check_eq("div0_hi", dut.RegFile.file_array[14], 32'd17);
    check_eq("div0_lo", dut.RegFile.file_array[15], 32'hFFFF_FFFF);
`else
    check_eq("nodiv_hi", dut.RegFile.file_array[9], 32'hA5);
    check_eq("nodiv_lo", dut.RegFile.file_array[10], 32'hA5);
    check_eq("nodiv0_hi", dut.RegFile.file_array[14], 32'hA5);
    check_eq("nodiv0_lo", dut.RegFile.file_array[15], 32'hA5);
`endif

    // $0 protection
    prep();
    set_reg(1, 32'd5);
    set_reg(11, 32'h55);
    emit(enc_r(1, 1, 0, 0, 32));
    emit(enc_r(0, 0, 11, 0, 32));
    emit(enc_j(8));
    go();
    repeat (15) @(negedge clk);
    check_eq("r0_read", dut.RegFile.file_array[11], 32'd0);
    check_eq("r0_file", dut.RegFile.file_array[0], 32'd0);

    // Reset while a store sits in MEM
    prep();
    set_reg(1, 32'hDEADBEEF);
    emit(enc_i(43, 0, 1, 8));
    emit(enc_j(4));
    go();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("rst_pc", dut.pc, 32'd0);
    @(posedge clk);
    #1;
    check_eq("rst_store", dmem_word(8), 32'd0);

    // Random programs against the architectural model
    for (int p = 0; p < 12; p++) begin
      prep();
      for (int i = 1; i < 32; i++)
        set_reg(i, ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 3)) : 32'($urandom));
      for (int i = 0; i < 1024; i++) set_byte(i, 8'($urandom));
      gen_random_program();
      go();
      repeat (150) @(negedge clk);
      model_run();
      for (int i = 0; i < 32; i++)
        check_eq($sformatf("rnd%0d_r%0d", p, i), dut.RegFile.file_array[i], m_reg[i]);
      for (int wi = 0; wi < 256; wi++)
        check_eq($sformatf("rnd%0d_m%0d", p, wi * 4), dmem_word(wi * 4),
                 {m_mem[wi*4+3], m_mem[wi*4+2], m_mem[wi*4+1], m_mem[wi*4]});
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
